// File: rtl/crop_pkg.sv
// crop_pkg: shared FSM encoding, default widths and coordinate clamp for the crop/pad stream blocks
package crop_pkg;
  typedef enum logic {IDLE, STREAM} state_t;
  localparam int PIXEL_BIT_WIDTH = 12;
  localparam int IMG_ROW_BITWIDTH = 10;
  localparam int IMG_COL_BITWIDTH = 10;
  function automatic int unsigned clamp_coord(input int unsigned value, input int unsigned limit);
    return value > limit ? limit : value;
  endfunction
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: single-entry valid/ready output register with data, last and (CROP_PAD_SOF_EN) user
module axis_out_reg #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_last,
`ifdef CROP_PAD_SOF_EN
  input  logic              d_user,
  output logic              tuser,
`endif
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              tlast
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tvalid <= 1'b0;
      tdata  <= '0;
      tlast  <= 1'b0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= d_data;
      tlast  <= d_last;
    end else if (tready)
      tvalid <= 1'b0;
`ifdef CROP_PAD_SOF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      tuser <= 1'b0;
    else if (load)
      tuser <= d_user;
`endif
endmodule

// File: rtl/crop_pad.sv
// crop_pad: places an IN_ROWS x IN_COLS tile at (Y1,X1) inside a PAD_VALUE raster frame; CROP_PAD_SOF_EN adds pixel_out_TUSER
module crop_pad #(
  parameter int PIXEL_BIT_WIDTH  = crop_pkg::PIXEL_BIT_WIDTH,
  parameter int IN_ROWS          = 20,
  parameter int IN_COLS          = 20,
  parameter int OUT_ROWS         = 40,
  parameter int OUT_COLS         = 40,
  parameter int IMG_ROW_BITWIDTH = crop_pkg::IMG_ROW_BITWIDTH,
  parameter int IMG_COL_BITWIDTH = crop_pkg::IMG_COL_BITWIDTH,
  parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PIXEL_BIT_WIDTH-1:0]  pixel_in_TDATA,
  input  logic                        pixel_in_TVALID,
  output logic                        pixel_in_TREADY,
  input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
  input  logic                        crop_Y1_TVALID,
  output logic                        crop_Y1_TREADY,
  input  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
  input  logic                        crop_X1_TVALID,
  output logic                        crop_X1_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
  output logic                        pixel_out_TVALID,
  input  logic                        pixel_out_TREADY,
  output logic                        pixel_out_TLAST
`ifdef CROP_PAD_SOF_EN
  , output logic                      pixel_out_TUSER
`endif
);
  import crop_pkg::*;
  state_t state, state_nx;
  logic [IMG_ROW_BITWIDTH-1:0] y, y1;
  logic [IMG_COL_BITWIDTH-1:0] x, x1;
  logic y_held, x_held, y_acc, x_acc, in_region, room, load, last_col, last_row, last_px;
  logic [PIXEL_BIT_WIDTH-1:0] d_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  always_comb
    state_nx = state == IDLE ? ((y_held || y_acc) && (x_held || x_acc) ? STREAM : IDLE)
                             : (load && last_px ? IDLE : STREAM);
  always_comb begin
    crop_Y1_TREADY  = state == IDLE && !y_held;
    crop_X1_TREADY  = state == IDLE && !x_held;
    y_acc           = crop_Y1_TVALID && crop_Y1_TREADY;
    x_acc           = crop_X1_TVALID && crop_X1_TREADY;
    in_region       = 32'(y) >= 32'(y1) && 32'(y) < 32'(y1) + IN_ROWS &&
                      32'(x) >= 32'(x1) && 32'(x) < 32'(x1) + IN_COLS;
    room            = !pixel_out_TVALID || pixel_out_TREADY;
    load            = state == STREAM && room && (!in_region || pixel_in_TVALID);
    pixel_in_TREADY = state == STREAM && in_region && room;
    last_col        = 32'(x) == OUT_COLS - 1;
    last_row        = 32'(y) == OUT_ROWS - 1;
    last_px         = last_col && last_row;
    d_data          = in_region ? pixel_in_TDATA : PAD_VALUE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= last_col ? '0 : x + 1'b1;
      y <= last_col ? (last_row ? '0 : y + 1'b1) : y;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      y_held <= 1'b0;
      x_held <= 1'b0;
      y1     <= '0;
      x1     <= '0;
    end else if (load && last_px) begin
      y_held <= 1'b0;
      x_held <= 1'b0;
    end else begin
      if (y_acc) begin
        y1     <= IMG_ROW_BITWIDTH'(clamp_coord(32'(crop_Y1_TDATA), OUT_ROWS - IN_ROWS));
        y_held <= 1'b1;
      end
      if (x_acc) begin
        x1     <= IMG_COL_BITWIDTH'(clamp_coord(32'(crop_X1_TDATA), OUT_COLS - IN_COLS));
        x_held <= 1'b1;
      end
    end
  axis_out_reg #(.DATA_W(PIXEL_BIT_WIDTH)) u_out (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .d_data (d_data),
    .d_last (last_px),
`ifdef CROP_PAD_SOF_EN
    .d_user (x == '0 && y == '0),
    .tuser  (pixel_out_TUSER),
`endif
    .tdata  (pixel_out_TDATA),
    .tvalid (pixel_out_TVALID),
    .tready (pixel_out_TREADY),
    .tlast  (pixel_out_TLAST)
  );
endmodule

// File: tb/tb_crop_pad.sv
// tb_crop_pad: randomized scoreboard bench for crop_pad against a frame-level placement model
module tb_crop_pad;
  localparam int N = 1600;
  localparam int T = 400;
  typedef struct packed {logic [11:0] d; logic l; logic u;} beat_t;
  logic clk = 0;
  logic reset = 0;
  logic [11:0] pixel_in_TDATA = 0;
  logic pixel_in_TVALID = 0;
  logic pixel_in_TREADY;
  logic [9:0] crop_Y1_TDATA = 0;
  logic crop_Y1_TVALID = 0;
  logic crop_Y1_TREADY;
  logic [9:0] crop_X1_TDATA = 0;
  logic crop_X1_TVALID = 0;
  logic crop_X1_TREADY;
  logic [11:0] pixel_out_TDATA;
  logic pixel_out_TVALID;
  logic pixel_out_TREADY = 1;
  logic pixel_out_TLAST;
`ifdef CROP_PAD_SOF_EN
  logic pixel_out_TUSER;
`endif
  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int out_count = 0;
  int tile_idx = 0;
  int tile_taken = 0;
  logic [11:0] tile[T];
  logic [11:0] got[N];
  logic got_last[N];

  crop_pad dut (
    .clk              (clk),
    .reset            (reset),
    .pixel_in_TDATA   (pixel_in_TDATA),
    .pixel_in_TVALID  (pixel_in_TVALID),
    .pixel_in_TREADY  (pixel_in_TREADY),
    .crop_Y1_TDATA    (crop_Y1_TDATA),
    .crop_Y1_TVALID   (crop_Y1_TVALID),
    .crop_Y1_TREADY   (crop_Y1_TREADY),
    .crop_X1_TDATA    (crop_X1_TDATA),
    .crop_X1_TVALID   (crop_X1_TVALID),
    .crop_X1_TREADY   (crop_X1_TREADY),
    .pixel_out_TDATA  (pixel_out_TDATA),
    .pixel_out_TVALID (pixel_out_TVALID),
    .pixel_out_TREADY (pixel_out_TREADY),
`ifdef CROP_PAD_SOF_EN
    .pixel_out_TUSER  (pixel_out_TUSER),
`endif
    .pixel_out_TLAST  (pixel_out_TLAST)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // scoreboard monitor: pops one expected beat per output handshake
  initial begin
    beat_t e;
    logic stalled;
    logic [11:0] hd;
    logic hl;
    stalled = 0;
    hd = 0;
    hl = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled = 0;
        out_count = 0;
        exp_q.delete();
      end else begin
        if (stalled) begin
          chk("stable_data", pixel_out_TDATA, hd);
          chk("stable_last", pixel_out_TLAST, hl);
        end
        if (pixel_out_TVALID && pixel_out_TREADY) begin
          if (exp_q.size() == 0)
            chk("unexpected_beat_queue_size", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk($sformatf("data[%0d]", out_count % N), pixel_out_TDATA, e.d);
            chk($sformatf("last[%0d]", out_count % N), pixel_out_TLAST, e.l);
`ifdef CROP_PAD_SOF_EN
            chk($sformatf("user[%0d]", out_count), pixel_out_TUSER, e.u);
`endif
          end
          got[out_count % N] = pixel_out_TDATA;
          got_last[out_count % N] = pixel_out_TLAST;
          out_count++;
        end
        stalled = pixel_out_TVALID && !pixel_out_TREADY;
        hd = pixel_out_TDATA;
        hl = pixel_out_TLAST;
      end
    end
  end

  task automatic fill_tile();
    for (int i = 0; i < T; i++) tile[i] = 12'($urandom_range(1, 4094));
  endtask

  task automatic run_frame(input int y1, input int x1, input bit rnd, input int y_lead, input int abort);
    beat_t e;
    int yc, xc, base, cyc;
    bit y_done, x_done, y_cap, x_cap, y_ck, x_ck;
    yc = y1 > 20 ? 20 : y1;
    xc = x1 > 20 ? 20 : x1;
    base = out_count;
    for (int i = 0; i < N; i++) begin
      int r, c;
      r = i / 40;
      c = i % 40;
      e.d = (r >= yc && r < yc + 20 && c >= xc && c < xc + 20) ? tile[(r - yc) * 20 + c - xc] : 12'd0;
      e.l = i == N - 1;
      e.u = i == 0;
      exp_q.push_back(e);
    end
    tile_idx = 0;
    tile_taken = 0;
    cyc = 0;
    {y_done, x_done, y_cap, x_cap, y_ck, x_ck} = '0;
    while (out_count - base < N && cyc < 20000) begin
      @(posedge clk);
      #1;
      crop_Y1_TDATA = 10'(y1);
      crop_X1_TDATA = 10'(x1);
      crop_Y1_TVALID = !y_done;
      crop_X1_TVALID = !x_done && cyc >= y_lead;
      pixel_in_TVALID = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      pixel_in_TDATA = tile_idx < T ? tile[tile_idx] : 12'hFFF;
      pixel_out_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (y_lead > 0) begin
        if (!x_cap) chk("no_out_before_x1", pixel_out_TVALID, 0);
        if (y_cap && !y_ck) begin chk("y1_tready_low", crop_Y1_TREADY, 0); y_ck = 1; end
        if (x_cap && !x_ck) begin chk("x1_tready_low", crop_X1_TREADY, 0); x_ck = 1; end
      end
      if (crop_Y1_TVALID && crop_Y1_TREADY) y_done = 1;
      if (crop_X1_TVALID && crop_X1_TREADY) x_done = 1;
      y_cap = y_done;
      x_cap = x_done;
      if (pixel_in_TVALID && pixel_in_TREADY) begin
        tile_idx++;
        tile_taken++;
      end
      if (abort > 0 && out_count - base >= abort) break;
      cyc++;
    end
    if (cyc >= 20000) chk("frame_timeout_beats", out_count - base, N);
  endtask

  task automatic drain_check();
    @(posedge clk);
    #1;
    pixel_out_TREADY = 1;
    pixel_in_TVALID = 1;
    repeat (4) @(negedge clk);
    chk("tile_beats", tile_taken, T);
    chk("frame_beats", out_count % N, 0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", pixel_out_TVALID, 0);
    chk("rst_out_data", pixel_out_TDATA, 0);
    chk("rst_out_last", pixel_out_TLAST, 0);
    chk("rst_in_ready", pixel_in_TREADY, 0);
    chk("rst_y1_ready", crop_Y1_TREADY, 1);
    chk("rst_x1_ready", crop_X1_TREADY, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    for (int i = 0; i < T; i++) tile[i] = 12'(i + 1);
    run_frame(5, 7, 0, 0, 0);
    chk("idx206", got[206], 0);
    chk("idx207", got[207], 1);
    chk("idx226", got[226], 20);
    chk("idx247", got[247], 21);
    chk("idx1598_last", got_last[1598], 0);
    chk("idx1599_last", got_last[1599], 1);
    drain_check();
    fill_tile();
    run_frame(30, 35, 0, 0, 0);
    chk("clamp_idx800", got[800], 0);
    chk("clamp_idx819", got[819], 0);
    chk("clamp_idx820", got[820], tile[0]);
    chk("clamp_idx1599", got[1599], tile[T - 1]);
    drain_check();
    for (int k = 0; k < 2; k++) begin
      fill_tile();
      run_frame($urandom_range(0, 40), $urandom_range(0, 40), 1, 0, 0);
      drain_check();
    end
    fill_tile();
    run_frame(12, 3, 0, 3, 0);
    drain_check();
    fill_tile();
    run_frame(9, 4, 1, 0, 500);
    @(posedge clk);
    #1 reset = 0;
    #1;
    chk("mid_rst_out_valid", pixel_out_TVALID, 0);
    chk("mid_rst_out_data", pixel_out_TDATA, 0);
    chk("mid_rst_out_last", pixel_out_TLAST, 0);
    chk("mid_rst_in_ready", pixel_in_TREADY, 0);
    chk("mid_rst_y1_ready", crop_Y1_TREADY, 1);
    chk("mid_rst_x1_ready", crop_X1_TREADY, 1);
    repeat (2) @(negedge clk);
    #1 reset = 1;
    fill_tile();
    run_frame(0, 0, 0, 0, 0);
    chk("after_rst_idx0", got[0], tile[0]);
    drain_check();
    for (int k = 0; k < 2; k++) begin
      fill_tile();
      run_frame($urandom_range(0, 25), $urandom_range(0, 25), 0, 0, 0);
    end
    drain_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
